// File: rtl/vn_debias.sv
// Von Neumann debiasing front end with an output bit FIFO.
// Optional build macro VN_DEBIAS_STATS_EN enables the pairs_dropped counter.
module vn_debias #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          raw_bit,
    input  logic                          raw_valid,
    input  logic                          bypass,
    input  logic                          clear,
    output logic                          out_bit,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              pairs_dropped
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state;
    logic                  first_q;
    logic [FIFO_DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic                  ovf_q;

    logic push_req;
    logic push_bit;
    logic pop;
    logic full;
    logic push_ok;

    // Select which bit (if any) is offered to the FIFO this cycle
    always_comb begin
        push_req = 1'b0;
        push_bit = 1'b0;
        if (bypass) begin
            push_req = raw_valid;
            push_bit = raw_bit;
        end else if (raw_valid && state == HOLD && first_q != raw_bit) begin
            push_req = 1'b1;
            push_bit = first_q;
        end
    end

    assign pop     = (level != '0) && out_ready;
    assign full    = (level == LW'(FIFO_DEPTH));
    assign push_ok = push_req && (!full || pop);

    // Pair tracking FSM; bypass abandons any half-pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            first_q <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            first_q <= 1'b0;
        end else if (bypass) begin
            state <= IDLE;
        end else if (raw_valid) begin
            if (state == IDLE) begin
                first_q <= raw_bit;
                state   <= HOLD;
            end else begin
                state <= IDLE;
            end
        end
    end

    // FIFO storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (!clear && push_ok) begin
            mem[wr_ptr] <= push_bit;
        end
    end

    // FIFO pointers and occupancy; a full FIFO accepts a push only alongside a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LW'(push_ok) - LW'(pop);
        end
    end

    // Sticky flag for a kept bit lost to a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (clear) begin
            ovf_q <= 1'b0;
        end else if (push_req && full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

`ifdef VN_DEBIAS_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic             drop;

    assign drop = !bypass && raw_valid && state == HOLD && first_q == raw_bit;

    // Saturating count of discarded equal pairs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (drop && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pairs_dropped = cnt_q;
`else
    assign pairs_dropped = '0;
`endif

    assign out_valid  = (level != '0);
    assign out_bit    = (level != '0) ? mem[rd_ptr] : 1'b0;
    assign fifo_level = level;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_vn_debias.sv
// Scoreboard bench for vn_debias.
// Expected output bits are queued as stimulus is driven.
module tb_vn_debias;

    localparam int DEPTH = 8;
    localparam int CW    = 16;
`ifdef VN_DEBIAS_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          raw_bit;
    logic          raw_valid;
    logic          bypass;
    logic          clear;
    logic          out_bit;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic [CW-1:0] pairs_dropped;

    int n_cmp;
    int n_err;
    bit exp_q[$];

    vn_debias #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raw_bit       (raw_bit),
        .raw_valid     (raw_valid),
        .bypass        (bypass),
        .clear         (clear),
        .out_bit       (out_bit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .pairs_dropped (pairs_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        raw_valid = 1'b0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || out_bit !== 1'b0) begin
            n_err++;
            $display("FAIL por_state valid=%b level=%0d bit=%b want 0/0/0",
                     out_valid, fifo_level, out_bit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b0;
        bypass    = 1'b0;
        raw_valid = 1'b1;
        raw_bit   = 1'b1;
        tick();
        tick();
        bypass = 1'b1;
        for (int i = 0; i < 3; i++) begin
            raw_bit = i[0];
            tick();
        end
        raw_valid = 1'b0;
        n_cmp++;
        if (fifo_level !== 4'd3) begin
            n_err++;
            $display("FAIL pre_reset_level got=%0d want=3", fifo_level);
        end
        n_cmp++;
        if (pairs_dropped !== CW'(STATS)) begin
            n_err++;
            $display("FAIL pre_reset_drop got=%0d want=%0d", pairs_dropped, STATS);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 ||
            pairs_dropped !== '0 || out_bit !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset v=%b lvl=%0d ovf=%b drop=%0d bit=%b want all 0",
                     out_valid, fifo_level, overflow, pairs_dropped, out_bit);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        bypass = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_debias();
        bit b[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit ev;
        bit e;
        do_clear();
        bypass    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raw_valid = 1'b1;
            raw_bit   = b[i];
            ev = (i % 2 == 1) ? (b[i-1] != b[i]) : 1'b0;
            if (ev) exp_q.push_back(b[i-1]);
            tick();
            n_cmp++;
            if (out_valid !== ev) begin
                n_err++;
                $display("FAIL debias_valid[%0d] got=%b want=%b", i, out_valid, ev);
            end
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (out_bit !== e) begin
                    n_err++;
                    $display("FAIL debias_bit[%0d] got=%b want=%b", i, out_bit, e);
                end
            end
        end
        raw_valid = 1'b0;
        tick();
        n_cmp++;
        if (pairs_dropped !== CW'(2 * STATS) || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL debias_drop got=%0d want=%0d left=%0d",
                     pairs_dropped, 2 * STATS, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int lvl = 0;
        int cnt = 0;
        bit e;
        do_clear();
        bypass    = 1'b0;
        out_ready = 1'b0;
        for (int p = 0; p < 9; p++) begin
            raw_valid = 1'b1;
            raw_bit   = 1'b1;
            tick();
            raw_bit = 1'b0;
            if (lvl < DEPTH) begin
                exp_q.push_back(1'b1);
                lvl++;
            end
            tick();
            if (p == 7) begin
                n_cmp++;
                if (overflow !== 1'b0 || fifo_level !== 4'd8) begin
                    n_err++;
                    $display("FAIL ovf_at_full ovf=%b lvl=%0d want 0/8", overflow, fifo_level);
                end
            end
        end
        raw_valid = 1'b0;
        n_cmp++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set lvl=%0d ovf=%b want 8/1", fifo_level, overflow);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (out_valid === 1'b1) begin
                cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
                n_cmp++;
                if (out_bit !== e) begin
                    n_err++;
                    $display("FAIL ovf_drain_bit[%0d] got=%b want=%b", cnt, out_bit, e);
                end
            end
            tick();
        end
        n_cmp++;
        if (cnt != 8 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_drain_count got=%0d want=8 valid=%b", cnt, out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        int cnt = 0;
        bit e;
        bit last = 1'b1;
        do_clear();
        out_ready = 1'b0;
        bypass    = 1'b1;
        raw_valid = 1'b1;
        raw_bit   = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(1'b1);
            tick();
        end
        bypass  = 1'b0;
        raw_bit = 1'b0;
        tick();
        raw_bit   = 1'b1;
        out_ready = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || out_bit !== e) begin
            n_err++;
            $display("FAIL fpp_head v=%b bit=%b want 1/%b", out_valid, out_bit, e);
        end
        exp_q.push_back(1'b0);
        tick();
        raw_valid = 1'b0;
        n_cmp++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fpp_level lvl=%0d ovf=%b want 8/0", fifo_level, overflow);
        end
        for (int k = 0; k < 12; k++) begin
            if (out_valid === 1'b1) begin
                cnt++;
                last = out_bit;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
                n_cmp++;
                if (out_bit !== e) begin
                    n_err++;
                    $display("FAIL fpp_drain_bit[%0d] got=%b want=%b", cnt, out_bit, e);
                end
            end
            tick();
        end
        n_cmp++;
        if (cnt != 8 || last !== 1'b0) begin
            n_err++;
            $display("FAIL fpp_drain count=%0d last=%b want 8/0", cnt, last);
        end
    endtask

    task automatic test_bypass_toggle();
        bit bp[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit rb[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int cnt = 0;
        bit e;
        do_clear();
        out_ready = 1'b1;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                raw_valid = 1'b1;
                bypass    = bp[k];
                raw_bit   = rb[k];
            end else begin
                raw_valid = 1'b0;
                bypass    = 1'b0;
            end
            if (out_valid === 1'b1) begin
                cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_bit;
                n_cmp++;
                if (out_bit !== e) begin
                    n_err++;
                    $display("FAIL byp_bit[%0d] got=%b want=%b", cnt, out_bit, e);
                end
            end
            tick();
        end
        n_cmp++;
        if (cnt != 3 || pairs_dropped !== '0) begin
            n_err++;
            $display("FAIL byp_count got=%0d drop=%0d want 3/0", cnt, pairs_dropped);
        end
    endtask

    task automatic test_clear();
        int cnt = 0;
        bit e;
        do_clear();
        out_ready = 1'b0;
        bypass    = 1'b1;
        raw_valid = 1'b1;
        raw_bit   = 1'b1;
        tick();
        tick();
        bypass = 1'b0;
        tick();
        n_cmp++;
        if (fifo_level !== 4'd2) begin
            n_err++;
            $display("FAIL clr_pre_level got=%0d want=2", fifo_level);
        end
        raw_bit = 1'b0;
        clear   = 1'b1;
        tick();
        clear     = 1'b0;
        raw_valid = 1'b0;
        n_cmp++;
        if (fifo_level !== 4'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_level got=%0d v=%b want 0/0", fifo_level, out_valid);
        end
        out_ready = 1'b1;
        exp_q.push_back(1'b0);
        for (int k = 0; k < 6; k++) begin
            raw_valid = (k < 2);
            raw_bit   = (k == 1);
            if (out_valid === 1'b1) begin
                cnt++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_bit;
                n_cmp++;
                if (out_bit !== e) begin
                    n_err++;
                    $display("FAIL clr_bit[%0d] got=%b want=%b", cnt, out_bit, e);
                end
            end
            tick();
        end
        n_cmp++;
        if (cnt != 1) begin
            n_err++;
            $display("FAIL clr_count got=%0d want=1", cnt);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        raw_bit   = 1'b0;
        raw_valid = 1'b0;
        bypass    = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_debias();
        test_overflow();
        test_full_push_pop();
        test_bypass_toggle();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
